regfile_port_arbiter: RTL and testbench
=======================================

# regfile_port_arbiter

Shares the register bank's single write port and read port A between the pipeline and a debug requester. Normal operation passes the write-back write straight through. A debug access works in four steps: stall the pipeline, wait a fixed drain window so in-flight write-backs retire, perform one register read or write, then acknowledge with a four-phase handshake. The block sits between the write-back stage, the debug unit and the instruction decode stage's register bank.

## Interface
- `SIZE`, 32, data width
- `NUM_REGISTERS`, 32, register count
- `SIZE_REG_DIR`, `$clog2(NUM_REGISTERS)`, register address width
- `DRAIN_CYCLES`, 3, cycles to wait after stalling; must be ≥1

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `i_wb_we` in 1: write-back write request.
- `i_wb_dir` in `SIZE_REG_DIR`: write-back register address.
- `i_wb_data` in `SIZE`: write-back data.
- `i_dec_dir_a` in `SIZE_REG_DIR`: decode read-A address (`instruction[25:21]`).
- `i_rd_data_a` in `SIZE`: bank read-A data; the bank read is combinational.
- `i_dbg_req` in 1: debug request, level, four-phase.
- `i_dbg_wr` in 1: 1 = write, 0 = read; sampled with the request.
- `i_dbg_dir` in `SIZE_REG_DIR`: debug register address.
- `i_dbg_wdata` in `SIZE`: debug write data.
- `o_write_enable` out 1: to the bank.
- `o_w_dir` out `SIZE_REG_DIR`: to the bank.
- `o_w_data` out `SIZE`: to the bank.
- `o_dir_a` out `SIZE_REG_DIR`: bank read-A address.
- `o_stall` out 1: freezes PC, IF/ID and the decode stage (`i_stall`).
- `o_dbg_ack` out 1: debug acknowledge.
- `o_dbg_rdata` out `SIZE`: registered read result.

## Operation
- States: IDLE, DRAIN, ACCESS, DONE. Register the state, the drain counter, the latched command (wr, dir, wdata), `o_stall`, `o_dbg_ack` and `o_dbg_rdata`.
- **IDLE:**
  - Write port = WB inputs; `o_dir_a` = `i_dec_dir_a`.
  - `i_dbg_req`=1 at an edge → latch the command; go to DRAIN; counter = `DRAIN_CYCLES`-1; `o_stall`=1.
- **DRAIN:**
  - WB pass-through stays active so the drained instructions retire.
  - Counter decrements each edge; at counter==0 go to ACCESS.
  - `i_dbg_req` dropped → IDLE, `o_stall`=0, no access, no ack.
- **ACCESS:**
  - If `i_wb_we`=1, WB owns the port and the block holds in ACCESS (late retirement always wins).
  - Else, debug write: `o_write_enable`=1, `o_w_dir`/`o_w_data` = latched dir/wdata. A write to dir 0 is suppressed (`o_write_enable`=0) but still acknowledged.
  - Else, debug read: `o_dir_a` = latched dir; capture `i_rd_data_a` into `o_dbg_rdata` at the edge.
  - Then go to DONE with `o_dbg_ack`=1.
- **DONE:**
  - `o_stall` and `o_dbg_ack` stay at 1; write port = WB pass-through; `o_dir_a` = `i_dec_dir_a`.
  - `i_dbg_req`=0 at an edge → IDLE, `o_dbg_ack`=0, `o_stall`=0.
  - `o_dbg_rdata` holds its value until the next read completes; writes do not change it.
- Changes to `i_dbg_*` after latching are ignored until the block returns to IDLE.

## Timing
- **Reset (`rst`=0):**
  - Immediately: state IDLE, counter 0, `o_stall`=0, `o_dbg_ack`=0, `o_dbg_rdata`=0.
  - Write-port and `o_dir_a` outputs are the IDLE pass-through.
  - Reset mid-access aborts it; a write is not performed unless the ACCESS edge has already occurred.
- **Latency:** request seen at edge E gives:
  - `o_stall` high after E;
  - ACCESS during cycle E+`DRAIN_CYCLES`;
  - ack high after edge E+`DRAIN_CYCLES`+1 (no WB conflict).
  - Each WB conflict cycle adds 1.
- **Release:** stall released one edge after the request drops in DONE. A new request needs at least one IDLE cycle, so the earliest re-stall is 2 edges after the drop.
- Write-port and read-address muxing are combinational from the registered state; no combinational path from `i_dbg_req` to any output.

## Test plan
- Reset mid-DRAIN: `rst`=0 asynchronously → `o_stall` falls without waiting for an edge; no ack; state IDLE.
- Debug write: req wr=1 dir=5 wdata=0xDEADBEEF, `DRAIN_CYCLES`=3 → `o_stall`=1 the next cycle; `o_write_enable`=1 with dir 5 / 0xDEADBEEF exactly one cycle, 3 cycles after the stall; ack follows; stall drops one edge after the request drops.
- Debug read: register 7 holds 0x12345678 → `o_dir_a`=7 only during ACCESS, `o_dbg_rdata`=0x12345678 with ack; otherwise `o_dir_a` tracks `i_dec_dir_a`.
- WB conflict: `i_wb_we`=1 (dir 3, 0x55) during ACCESS for 2 cycles → WB write passes, the debug write is delayed 2 cycles, and both writes land in the bank.
- Abort in DRAIN: request drops after 1 cycle → IDLE, `o_stall`=0 next edge, no write, no ack. Write to dir 0: ack asserted, `o_write_enable` stays 0.

Source files
------------

// File: rtl/regfile_port_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_port_arbiter
//
// Shares the register bank's single write port and read port A between the
// pipeline write-back stage and a debug requester. Normally the write-back
// write goes straight to the bank and read port A follows the decode stage.
// A debug access stalls the pipeline, waits DRAIN_CYCLES so in-flight
// write-backs retire, performs one register read or write, then holds an
// acknowledge until the requester drops its request (four-phase handshake).
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   i_wb_we/dir/data  write-back write request
//   i_dec_dir_a       decode-stage read-A address
//   i_rd_data_a       bank read-A data (combinational bank read)
//   i_dbg_req         debug request level; i_dbg_wr/dir/wdata sampled with it
//   o_write_enable,
//   o_w_dir, o_w_data bank write port
//   o_dir_a           bank read-A address
//   o_stall           freezes PC, IF/ID and decode
//   o_dbg_ack         debug acknowledge
//   o_dbg_rdata       registered result of the last debug read
// -----------------------------------------------------------------------------
module regfile_port_arbiter #(
   parameter int SIZE          = 32,
   parameter int NUM_REGISTERS = 32,
   parameter int SIZE_REG_DIR  = $clog2(NUM_REGISTERS),
   parameter int DRAIN_CYCLES  = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_wb_we,
   input  logic [SIZE_REG_DIR-1:0] i_wb_dir,
   input  logic [SIZE-1:0]         i_wb_data,
   input  logic [SIZE_REG_DIR-1:0] i_dec_dir_a,
   input  logic [SIZE-1:0]         i_rd_data_a,
   input  logic                    i_dbg_req,
   input  logic                    i_dbg_wr,
   input  logic [SIZE_REG_DIR-1:0] i_dbg_dir,
   input  logic [SIZE-1:0]         i_dbg_wdata,
   output logic                    o_write_enable,
   output logic [SIZE_REG_DIR-1:0] o_w_dir,
   output logic [SIZE-1:0]         o_w_data,
   output logic [SIZE_REG_DIR-1:0] o_dir_a,
   output logic                    o_stall,
   output logic                    o_dbg_ack,
   output logic [SIZE-1:0]         o_dbg_rdata
);

   localparam int               CNT_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_ACCESS,
      ST_DONE
   } state_t;

   state_t                  r_state,     w_state_nxt;
   logic [CNT_W-1:0]        r_cnt,       w_cnt_nxt;
   logic                    r_cmd_wr,    w_cmd_wr_nxt;
   logic [SIZE_REG_DIR-1:0] r_cmd_dir,   w_cmd_dir_nxt;
   logic [SIZE-1:0]         r_cmd_wdata, w_cmd_wdata_nxt;
   logic                    r_stall,     w_stall_nxt;
   logic                    r_ack,       w_ack_nxt;
   logic [SIZE-1:0]         r_rdata,     w_rdata_nxt;

   // Debug owns the ports only in ACCESS and only while write-back is idle;
   // a late write-back retiring during ACCESS always wins the port.
   logic w_dbg_turn;
   assign w_dbg_turn = (r_state == ST_ACCESS) && !i_wb_we;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_cmd_wr    <= 1'b0;
         r_cmd_dir   <= '0;
         r_cmd_wdata <= '0;
         r_stall     <= 1'b0;
         r_ack       <= 1'b0;
         r_rdata     <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_cmd_wr    <= w_cmd_wr_nxt;
         r_cmd_dir   <= w_cmd_dir_nxt;
         r_cmd_wdata <= w_cmd_wdata_nxt;
         r_stall     <= w_stall_nxt;
         r_ack       <= w_ack_nxt;
         r_rdata     <= w_rdata_nxt;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_cmd_wr_nxt    = r_cmd_wr;
      w_cmd_dir_nxt   = r_cmd_dir;
      w_cmd_wdata_nxt = r_cmd_wdata;
      w_stall_nxt     = r_stall;
      w_ack_nxt       = r_ack;
      w_rdata_nxt     = r_rdata;

      case (r_state)
         ST_IDLE: begin
            // The command is captured only here; later changes on the
            // debug lines are ignored until the handshake completes.
            if (i_dbg_req) begin
               w_cmd_wr_nxt    = i_dbg_wr;
               w_cmd_dir_nxt   = i_dbg_dir;
               w_cmd_wdata_nxt = i_dbg_wdata;
               w_cnt_nxt       = CNT_LOAD;
               w_stall_nxt     = 1'b1;
               w_state_nxt     = ST_DRAIN;
            end
         end

         ST_DRAIN: begin
            // Dropping the request while draining aborts with no access.
            if (!i_dbg_req) begin
               w_cnt_nxt   = '0;
               w_stall_nxt = 1'b0;
               w_state_nxt = ST_IDLE;
            end else if (r_cnt == '0) begin
               w_state_nxt = ST_ACCESS;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end

         ST_ACCESS: begin
            if (w_dbg_turn) begin
               if (!r_cmd_wr) begin
                  w_rdata_nxt = i_rd_data_a;
               end
               w_ack_nxt   = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end

         ST_DONE: begin
            if (!i_dbg_req) begin
               w_ack_nxt   = 1'b0;
               w_stall_nxt = 1'b0;
               w_state_nxt = ST_IDLE;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------- port muxing
   // Driven only from registered state plus the write-back / decode lines,
   // so i_dbg_req never reaches an output combinationally.
   always_comb begin
      o_write_enable = i_wb_we;
      o_w_dir        = i_wb_dir;
      o_w_data       = i_wb_data;
      o_dir_a        = i_dec_dir_a;

      if (w_dbg_turn) begin
         if (r_cmd_wr) begin
            // Register 0 is hard-wired; the write is dropped but still acked.
            o_write_enable = (r_cmd_dir != '0);
            o_w_dir        = r_cmd_dir;
            o_w_data       = r_cmd_wdata;
         end else begin
            o_dir_a = r_cmd_dir;
         end
      end
   end

   assign o_stall     = r_stall;
   assign o_dbg_ack   = r_ack;
   assign o_dbg_rdata = r_rdata;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_port_arbiter
//
// Drives write-back traffic and debug transactions cycle by cycle. The driver
// computes, from the documented handshake timing, when each bank write,
// stall edge, ack rise and debug read address should appear and pushes those
// events into queues; a monitor on the falling edge pops and compares them
// whenever the DUT shows the corresponding activity. A model register bank
// supplies the expected debug read data.
// -----------------------------------------------------------------------------
module tb_regfile_port_arbiter;

   localparam int SIZE = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;
   localparam int D    = 3;

   typedef struct { int cyc; logic [AW-1:0] dir; logic [SIZE-1:0] data; } wr_ev_t;
   typedef struct { int cyc; logic lvl; } lvl_ev_t;
   typedef struct { int cyc; logic [SIZE-1:0] rdata; } ack_ev_t;
   typedef struct { int cyc; logic [AW-1:0] dir; } dir_ev_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            i_wb_we;
   logic [AW-1:0]   i_wb_dir;
   logic [SIZE-1:0] i_wb_data;
   logic [AW-1:0]   i_dec_dir_a;
   logic [SIZE-1:0] i_rd_data_a;
   logic            i_dbg_req;
   logic            i_dbg_wr;
   logic [AW-1:0]   i_dbg_dir;
   logic [SIZE-1:0] i_dbg_wdata;
   logic            o_write_enable;
   logic [AW-1:0]   o_w_dir;
   logic [SIZE-1:0] o_w_data;
   logic [AW-1:0]   o_dir_a;
   logic            o_stall;
   logic            o_dbg_ack;
   logic [SIZE-1:0] o_dbg_rdata;

   regfile_port_arbiter #(
      .SIZE(SIZE), .NUM_REGISTERS(NREG), .SIZE_REG_DIR(AW), .DRAIN_CYCLES(D)
   ) dut (
      .clk(clk), .rst(rst),
      .i_wb_we(i_wb_we), .i_wb_dir(i_wb_dir), .i_wb_data(i_wb_data),
      .i_dec_dir_a(i_dec_dir_a), .i_rd_data_a(i_rd_data_a),
      .i_dbg_req(i_dbg_req), .i_dbg_wr(i_dbg_wr), .i_dbg_dir(i_dbg_dir),
      .i_dbg_wdata(i_dbg_wdata),
      .o_write_enable(o_write_enable), .o_w_dir(o_w_dir), .o_w_data(o_w_data),
      .o_dir_a(o_dir_a), .o_stall(o_stall), .o_dbg_ack(o_dbg_ack),
      .o_dbg_rdata(o_dbg_rdata)
   );

   always #5 clk = ~clk;

   // Environment: the register bank the DUT talks to.
   logic [SIZE-1:0] bank [NREG] = '{default: '0};
   assign i_rd_data_a = bank[o_dir_a];
   always @(posedge clk) if (o_write_enable) bank[o_w_dir] <= o_w_data;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model state
   logic [SIZE-1:0] ref_bank [NREG] = '{default: '0};
   logic [SIZE-1:0] last_rd = '0;

   wr_ev_t  wq[$];
   lvl_ev_t sq[$];
   ack_ev_t aq[$];
   dir_ev_t dq[$];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input bit ok, input string detail);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: %s", name, detail);
      end
   endtask

   // ------------------------------------------------------------- monitor
   logic prev_stall = 1'b0;
   logic prev_ack   = 1'b0;
   always @(negedge clk) begin
      wr_ev_t  w;
      lvl_ev_t s;
      ack_ev_t a;
      dir_ev_t d;
      if (o_write_enable) begin
         if (wq.size() == 0)
            check("wr_unexpected", 1'b0, $sformatf("cyc %0d dir %0d data %h, none expected", cyc, o_w_dir, o_w_data));
         else begin
            w = wq.pop_front();
            check("bank_write", cyc == w.cyc && o_w_dir == w.dir && o_w_data == w.data,
                  $sformatf("got cyc %0d dir %0d data %h, want cyc %0d dir %0d data %h",
                            cyc, o_w_dir, o_w_data, w.cyc, w.dir, w.data));
         end
      end
      if (o_stall !== prev_stall) begin
         if (sq.size() == 0)
            check("stall_unexpected", 1'b0, $sformatf("cyc %0d stall %b, no edge expected", cyc, o_stall));
         else begin
            s = sq.pop_front();
            check("stall_edge", cyc == s.cyc && o_stall == s.lvl,
                  $sformatf("got cyc %0d lvl %b, want cyc %0d lvl %b", cyc, o_stall, s.cyc, s.lvl));
         end
      end
      if (o_dbg_ack && !prev_ack) begin
         if (aq.size() == 0)
            check("ack_unexpected", 1'b0, $sformatf("ack rose at cyc %0d, none expected", cyc));
         else begin
            a = aq.pop_front();
            check("ack_rise", cyc == a.cyc && o_dbg_rdata == a.rdata,
                  $sformatf("got cyc %0d rdata %h, want cyc %0d rdata %h", cyc, o_dbg_rdata, a.cyc, a.rdata));
         end
      end
      if (!o_dbg_ack && prev_ack)
         check("ack_fall_with_stall", !o_stall, $sformatf("cyc %0d stall %b, want 0", cyc, o_stall));
      if (o_dir_a !== i_dec_dir_a) begin
         if (dq.size() == 0)
            check("dira_unexpected", 1'b0, $sformatf("cyc %0d dir_a %0d dec %0d", cyc, o_dir_a, i_dec_dir_a));
         else begin
            d = dq.pop_front();
            check("dbg_read_addr", cyc == d.cyc && o_dir_a == d.dir,
                  $sformatf("got cyc %0d dir %0d, want cyc %0d dir %0d", cyc, o_dir_a, d.cyc, d.dir));
         end
      end
      prev_stall = o_stall;
      prev_ack   = o_dbg_ack;
   end

   // -------------------------------------------------------------- driver
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_wr(input logic [AW-1:0] d, input logic [SIZE-1:0] v);
      wr_ev_t ev;
      ev.cyc = cyc; ev.dir = d; ev.data = v;
      wq.push_back(ev);
      ref_bank[d] = v;
   endtask

   task automatic push_lvl(input int c, input logic l);
      lvl_ev_t ev;
      ev.cyc = c; ev.lvl = l;
      sq.push_back(ev);
   endtask

   task automatic wb_none();
      i_wb_we     = 1'b0;
      i_wb_dir    = AW'($urandom);
      i_wb_data   = $urandom;
      i_dec_dir_a = AW'($urandom);
   endtask

   task automatic wb_rand();
      wb_none();
      i_wb_we = ($urandom_range(0, 2) == 0);
      if (i_wb_we) push_wr(i_wb_dir, i_wb_data);
   endtask

   // One debug transaction. abort_at >= 0 drops the request in that drain
   // cycle; nconf write-back writes (cdir/cdata) collide with ACCESS.
   task automatic dbg_txn(input logic wr, input logic [AW-1:0] dir, input logic [SIZE-1:0] wd,
                          input int nconf, input logic [AW-1:0] cdir, input logic [SIZE-1:0] cdata,
                          input int abort_at, input int hold);
      ack_ev_t a;
      dir_ev_t de;
      i_dbg_req = 1'b1; i_dbg_wr = wr; i_dbg_dir = dir; i_dbg_wdata = wd;
      wb_rand();
      push_lvl(cyc + 1, 1'b1);
      tick();
      for (int i = 0; i < D; i++) begin
         i_dbg_wr = 1'($urandom); i_dbg_dir = AW'($urandom); i_dbg_wdata = $urandom;
         if (i == abort_at) begin
            i_dbg_req = 1'b0;
            wb_rand();
            push_lvl(cyc + 1, 1'b0);
            tick();
            return;
         end
         wb_rand();
         tick();
      end
      for (int i = 0; i < nconf; i++) begin
         wb_none();
         i_wb_we = 1'b1; i_wb_dir = cdir; i_wb_data = cdata;
         if (!wr) i_dec_dir_a = dir;
         push_wr(cdir, cdata);
         tick();
      end
      wb_none();
      if (wr) begin
         if (dir != '0) push_wr(dir, wd);
      end else begin
         i_dec_dir_a = dir ^ AW'(1);
         de.cyc = cyc; de.dir = dir;
         dq.push_back(de);
         last_rd = ref_bank[dir];
      end
      a.cyc = cyc + 1; a.rdata = last_rd;
      aq.push_back(a);
      tick();
      for (int i = 0; i < hold; i++) begin
         wb_rand();
         tick();
      end
      i_dbg_req = 1'b0;
      wb_rand();
      push_lvl(cyc + 1, 1'b0);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      i_dbg_req = 1'b0; i_dbg_wr = 1'b0; i_dbg_dir = '0; i_dbg_wdata = '0;
      wb_none();
      #2 rst = 1'b0;
      #1;
      check("reset_stall", o_stall == 1'b0, $sformatf("got %b want 0", o_stall));
      check("reset_ack", o_dbg_ack == 1'b0, $sformatf("got %b want 0", o_dbg_ack));
      check("reset_rdata", o_dbg_rdata == '0, $sformatf("got %h want 0", o_dbg_rdata));
      tick(); tick();
      rst = 1'b1;
      wb_none();
      tick();

      // Reset in the middle of DRAIN: stall must drop without a clock edge.
      i_dbg_req = 1'b1; i_dbg_wr = 1'b1; i_dbg_dir = AW'(9); i_dbg_wdata = 32'hA5A5_0009;
      wb_none();
      push_lvl(cyc + 1, 1'b1);
      tick();
      wb_none(); tick();
      #2 rst = 1'b0; i_dbg_req = 1'b0;
      push_lvl(cyc, 1'b0);
      #1;
      check("async_reset_stall", o_stall == 1'b0, $sformatf("got %b want 0", o_stall));
      check("async_reset_ack", o_dbg_ack == 1'b0, $sformatf("got %b want 0", o_dbg_ack));
      tick();
      rst = 1'b1;
      wb_rand(); tick();
      wb_rand(); tick();

      // Directed cases
      dbg_txn(1'b1, AW'(5), 32'hDEAD_BEEF, 0, '0, '0, -1, 2);
      wb_none(); i_wb_we = 1'b1; i_wb_dir = AW'(7); i_wb_data = 32'h1234_5678;
      push_wr(AW'(7), 32'h1234_5678);
      tick();
      dbg_txn(1'b0, AW'(7), 32'h0, 0, '0, '0, -1, 1);
      dbg_txn(1'b1, AW'(10), 32'hCAFE_F00D, 2, AW'(3), 32'h55, -1, 0);
      dbg_txn(1'b0, AW'(3), 32'h0, 0, '0, '0, -1, 0);
      dbg_txn(1'b0, AW'(10), 32'h0, 0, '0, '0, -1, 0);
      dbg_txn(1'b1, AW'(12), 32'hBAD0_BAD0, 0, '0, '0, 0, 0);
      wb_none(); tick();
      dbg_txn(1'b0, AW'(12), 32'h0, 1, AW'(4), 32'h44, -1, 0);
      dbg_txn(1'b1, AW'(0), 32'hFFFF_FFFF, 0, '0, '0, -1, 1);
      dbg_txn(1'b0, AW'(5), 32'h0, 0, '0, '0, -1, 0);

      // Randomized transactions
      for (int t = 0; t < 40; t++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin wb_rand(); tick(); end
         dbg_txn(1'($urandom), AW'($urandom_range(0, NREG - 1)), $urandom,
                 $urandom_range(0, 2), AW'($urandom), $urandom,
                 ($urandom_range(0, 5) == 0) ? $urandom_range(0, D - 1) : -1,
                 $urandom_range(0, 3));
      end

      for (int g = 0; g < 4; g++) begin wb_none(); tick(); end
      check("writes_drained", wq.size() == 0, $sformatf("%0d writes never seen", wq.size()));
      check("stall_edges_drained", sq.size() == 0, $sformatf("%0d stall edges never seen", sq.size()));
      check("acks_drained", aq.size() == 0, $sformatf("%0d acks never seen", aq.size()));
      check("reads_drained", dq.size() == 0, $sformatf("%0d read addresses never seen", dq.size()));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
